// File: rtl/vram_grid_scanout_if.sv
// RAM read port and VGA output bundle of the grid scanout block.
// master = scanout engine, slave = RAM read side / VGA mux.
interface vram_grid_scanout_if;
    logic       RAM_RCLK;
    logic [3:0] RAM_RADDR;
    logic [7:0] RAM_RDATA;
    logic       VGA_R;
    logic       VGA_G;
    logic       VGA_B;
    logic       VGA_HSYNC;
    logic       VGA_VSYNC;
    logic       FRAME_START;

    modport master (
        output RAM_RCLK, RAM_RADDR,
        output VGA_R, VGA_G, VGA_B, VGA_HSYNC, VGA_VSYNC, FRAME_START,
        input  RAM_RDATA
    );

    modport slave (
        input  RAM_RCLK, RAM_RADDR,
        input  VGA_R, VGA_G, VGA_B, VGA_HSYNC, VGA_VSYNC, FRAME_START,
        output RAM_RDATA
    );
endinterface

// File: rtl/vram_grid_scanout.sv
// Scans a 16-entry video RAM out as a 4x4 colour grid on 640x480@60 VGA.
// Optional cell borders are compiled in with macro VRAM_GRID_BORDER_EN.
module vram_grid_scanout #(
    parameter int CELL_W = 160,
    parameter int CELL_H = 120,
    parameter int BORDER = 4
) (
    input  logic                        CLK_VGA,
    input  logic                        RST_N,
    vram_grid_scanout_if.master         vif
);
    localparam int CX_W = $clog2(CELL_W);
    localparam int CY_W = $clog2(CELL_H);

    localparam logic [9:0] H_VIS  = 10'd640;
    localparam logic [9:0] H_SYNC = 10'd656;
    localparam logic [9:0] H_BP   = 10'd752;
    localparam logic [9:0] H_LAST = 10'd799;
    localparam logic [9:0] V_VIS  = 10'd480;
    localparam logic [9:0] V_SYNC = 10'd490;
    localparam logic [9:0] V_BP   = 10'd492;
    localparam logic [9:0] V_LAST = 10'd524;

    localparam logic [CX_W-1:0] CX_LAST = CX_W'(CELL_W - 1);
    localparam logic [CY_W-1:0] CY_LAST = CY_W'(CELL_H - 1);

    // Colour of one output pixel: blank outside the visible area.
    function automatic logic [2:0] cell_colour(input logic vld, input logic brd,
                                               input logic [7:0] d);
        if (!vld) return 3'b000;
        return brd ? d[5:3] : d[2:0];
    endfunction

    logic [9:0]      hc_q, hc_d, vc_q, vc_d;
    logic [CX_W-1:0] cx_q, cx_d;
    logic [CY_W-1:0] cy_q, cy_d;
    logic [1:0]      col_q, col_d, row_q, row_d;

    logic vld_s0, hs_s0, vs_s0, fs_s0;
    logic vld_p1_q, hs_p1_q, vs_p1_q, fs_p1_q;
    logic [2:0] rgb_p2_q;
    logic hs_p2_q, vs_p2_q, fs_p2_q;
    logic brd_sel;
    logic unused_rdata;

    assign unused_rdata = ^vif.RAM_RDATA[7:6];

    always_comb begin
        hc_d  = hc_q;
        vc_d  = vc_q;
        cx_d  = cx_q;
        col_d = col_q;
        cy_d  = cy_q;
        row_d = row_q;
        if (hc_q == H_LAST) begin
            hc_d  = 10'd0;
            cx_d  = '0;
            col_d = 2'd0;
            if (vc_q == V_LAST) begin
                vc_d  = 10'd0;
                cy_d  = '0;
                row_d = 2'd0;
            end else begin
                vc_d = vc_q + 10'd1;
                // Row 3 wraps to 0 on the last visible line, so blanking reads row 0.
                if (vc_q < V_VIS) begin
                    if (cy_q == CY_LAST) begin
                        cy_d  = '0;
                        row_d = row_q + 2'd1;
                    end else begin
                        cy_d = cy_q + CY_W'(1);
                    end
                end
            end
        end else begin
            hc_d = hc_q + 10'd1;
            if (hc_q < H_VIS) begin
                if (cx_q == CX_LAST) begin
                    cx_d  = '0;
                    col_d = col_q + 2'd1;
                end else begin
                    cx_d = cx_q + CX_W'(1);
                end
            end
        end
    end

    // Stage 0: counters drive the RAM address and the raw timing flags.
    assign vif.RAM_RCLK  = CLK_VGA;
    assign vif.RAM_RADDR = {row_q, col_q};
    assign vld_s0 = (hc_q < H_VIS) && (vc_q < V_VIS);
    assign hs_s0  = !((hc_q >= H_SYNC) && (hc_q < H_BP));
    assign vs_s0  = !((vc_q >= V_SYNC) && (vc_q < V_BP));
    assign fs_s0  = (hc_q == 10'd0) && (vc_q == 10'd0);

`ifdef VRAM_GRID_BORDER_EN
    localparam logic [CX_W-1:0] BX_LO = CX_W'(BORDER);
    localparam logic [CX_W-1:0] BX_HI = CX_W'(CELL_W - BORDER);
    localparam logic [CY_W-1:0] BY_LO = CY_W'(BORDER);
    localparam logic [CY_W-1:0] BY_HI = CY_W'(CELL_H - BORDER);

    logic brd_s0, brd_p1_q;
    assign brd_s0 = (cx_q < BX_LO) || (cx_q >= BX_HI) ||
                    (cy_q < BY_LO) || (cy_q >= BY_HI);

    always_ff @(posedge CLK_VGA or negedge RST_N) begin
        if (!RST_N) brd_p1_q <= 1'b0;
        else        brd_p1_q <= brd_s0;
    end
    assign brd_sel = brd_p1_q;
`else
    assign brd_sel = 1'b0;
`endif

    always_ff @(posedge CLK_VGA or negedge RST_N) begin
        if (!RST_N) begin
            hc_q     <= 10'd0;
            vc_q     <= 10'd0;
            cx_q     <= '0;
            cy_q     <= '0;
            col_q    <= 2'd0;
            row_q    <= 2'd0;
            vld_p1_q <= 1'b0;
            hs_p1_q  <= 1'b1;
            vs_p1_q  <= 1'b1;
            fs_p1_q  <= 1'b0;
            rgb_p2_q <= 3'b000;
            hs_p2_q  <= 1'b1;
            vs_p2_q  <= 1'b1;
            fs_p2_q  <= 1'b0;
        end else begin
            hc_q     <= hc_d;
            vc_q     <= vc_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            col_q    <= col_d;
            row_q    <= row_d;
            // Stage 1: flags wait here while the RAM returns the cell data.
            vld_p1_q <= vld_s0;
            hs_p1_q  <= hs_s0;
            vs_p1_q  <= vs_s0;
            fs_p1_q  <= fs_s0;
            // Stage 2: registered pixel outputs.
            rgb_p2_q <= cell_colour(vld_p1_q, brd_sel, vif.RAM_RDATA);
            hs_p2_q  <= hs_p1_q;
            vs_p2_q  <= vs_p1_q;
            fs_p2_q  <= fs_p1_q;
        end
    end

    assign vif.VGA_R       = rgb_p2_q[2];
    assign vif.VGA_G       = rgb_p2_q[1];
    assign vif.VGA_B       = rgb_p2_q[0];
    assign vif.VGA_HSYNC   = hs_p2_q;
    assign vif.VGA_VSYNC   = vs_p2_q;
    assign vif.FRAME_START = fs_p2_q;
endmodule

// File: tb/tb_vram_grid_scanout.sv
// Scoreboard bench for vram_grid_scanout: a pixel-level reference model pushes
// expected outputs, a negedge monitor pops and compares them 2 cycles later.
module tb_vram_grid_scanout;
    localparam int CW = 40;
    localparam int CH = 10;
    localparam int BD = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    vram_grid_scanout_if vif();

    vram_grid_scanout #(.CELL_W(CW), .CELL_H(CH), .BORDER(BD)) dut (
        .CLK_VGA (clk),
        .RST_N   (rst_n),
        .vif     (vif)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [16];
    initial vif.RAM_RDATA = 8'h00;
    always @(posedge vif.RAM_RCLK) vif.RAM_RDATA <= mem[vif.RAM_RADDR];

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned tgt;
        int          hc;
        int          vc;
        logic [5:0]  exp;
    } exp_t;
    exp_t sbq[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input int hc, input int vc,
                         input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 25)
                $display("FAIL %s at hc=%0d vc=%0d: got %b, expected %b", nm, hc, vc, act, exp);
        end
    endtask

    function automatic logic [5:0] outs();
        return {vif.VGA_R, vif.VGA_G, vif.VGA_B, vif.VGA_HSYNC, vif.VGA_VSYNC, vif.FRAME_START};
    endfunction

    function automatic int cell_addr(input int hc, input int vc);
        int col, row;
        col = (hc < 640) ? (hc / CW) % 4 : 0;
        row = (vc < 480) ? (vc / CH) % 4 : 0;
        return row * 4 + col;
    endfunction

    // Expected {R,G,B,HSYNC,VSYNC,FRAME_START} for the pixel at (hc,vc) given cell data d.
    function automatic logic [5:0] pixel_model(input int hc, input int vc, input logic [7:0] d);
        logic       vis, brd, hs, vs, fs;
        logic [2:0] rgb;
        int         cx, cy;
        vis = (hc < 640) && (vc < 480);
        cx  = hc % CW;
        cy  = vc % CH;
        brd = 1'b0;
`ifdef VRAM_GRID_BORDER_EN
        brd = (cx < BD) || (cx >= CW - BD) || (cy < BD) || (cy >= CH - BD);
`endif
        rgb = !vis ? 3'b000 : (brd ? d[5:3] : d[2:0]);
        hs  = !(hc >= 656 && hc <= 751);
        vs  = !(vc >= 490 && vc <= 491);
        fs  = (hc == 0) && (vc == 0);
        return {rgb, hs, vs, fs};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        while (sbq.size() > 0 && sbq[0].tgt < cyc) begin
            e = sbq.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL stale_entry hc=%0d vc=%0d: due at cycle %0d, now %0d", e.hc, e.vc, e.tgt, cyc);
        end
        if (sbq.size() > 0 && sbq[0].tgt == cyc) begin
            e = sbq.pop_front();
            check("pixel", e.hc, e.vc, {2'b00, outs()}, {2'b00, e.exp});
        end
    end

    // Called at a negedge right after reset release; scans from (0,0) for ncyc cycles,
    // or until the model reaches (rst_hc,rst_vc), where it asserts reset mid-frame.
    task automatic run_cycles(input int ncyc, input bit rand_wr, input int rst_hc, input int rst_vc);
        int hc = 0;
        int vc = 0;
        int a;
        exp_t e;
        for (int k = 0; k < ncyc; k++) begin
            if (hc == rst_hc && vc == rst_vc) begin
                #2 rst_n = 1'b0;
                #1;
                check("async_reset_out", hc, vc, {2'b00, outs()}, 8'b0000_0110);
                check("async_reset_addr", hc, vc, {4'h0, vif.RAM_RADDR}, 8'h00);
                sbq.delete();
                return;
            end
            if (rand_wr && $urandom_range(0, 63) == 0)
                mem[$urandom_range(0, 15)] = 8'($urandom);
            a = cell_addr(hc, vc);
            check("raddr", hc, vc, {4'h0, vif.RAM_RADDR}, 8'(a));
            e.tgt = cyc + 2;
            e.hc  = hc;
            e.vc  = vc;
            e.exp = pixel_model(hc, vc, mem[a]);
            sbq.push_back(e);
            if (hc == 799) begin
                hc = 0;
                vc = (vc == 524) ? 0 : vc + 1;
            end else begin
                hc = hc + 1;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        for (int n = 0; n < 16; n++) mem[n] = {5'b00000, 3'(n)};
        mem[5] = 8'b00_100_001;

        rst_n = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check("reset_out", -1, -1, {2'b00, outs()}, 8'b0000_0110);
            check("reset_addr", -1, -1, {4'h0, vif.RAM_RADDR}, 8'h00);
        end
        rst_n = 1'b1;
        run_cycles(22 * 800, 1'b0, 300, 20);

        repeat (3) begin
            @(negedge clk);
            check("reset_hold_out", -1, -1, {2'b00, outs()}, 8'b0000_0110);
        end
        for (int n = 0; n < 16; n++) mem[n] = 8'($urandom);
        rst_n = 1'b1;
        run_cycles(50 * 800, 1'b1, -1, -1);

        repeat (3) @(negedge clk);
        check("drain", -1, -1, 8'(sbq.size()), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
